// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the control bundle carried down the ID/EX, EX/MEM and MEM/WB registers.
// Purely declarative: no latency, no flow control.
package pipe_ctrl_pkg;

    localparam int RA_W = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        PC_PLUS4 = 3'b000, PC_BRANCH, PC_JAL, PC_JALR, PC_TRAP
    } next_pc_sel_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'b000, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_e;

    localparam logic [1:0] SRC1_RS1 = 2'd0, SRC1_PC  = 2'd1, SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_RS2 = 2'd0, SRC2_IMM = 2'd1;
    localparam logic [1:0] WB_ALU   = 2'd0, WB_MEM   = 2'd1, WB_PC4    = 2'd2;

    // valid marks a real instruction; it is what the retire counter looks at.
    typedef struct packed {
        logic            valid;
        logic [3:0]      alu_op;
        logic [1:0]      src1_sel;
        logic [1:0]      src2_sel;
        logic            mem_wen;
        logic [2:0]      funct3;
        logic            mem_signed;
        logic            rf_wen;
        logic [1:0]      wdata_sel;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            use_rs1;
        logic            use_rs2;
        logic            is_load;
        logic            is_branch;
        logic            is_jump;
        logic            is_jalr;
        logic            illegal;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                         input logic lt, input logic ltu);
        case (f3)
            3'b000:  return eq;
            3'b001:  return !eq;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_controller_hazard_unit.sv
// Forwarding selects, RAW/load-use stall and EX redirect; purely combinational, zero latency.
// A redirect (flush) overrides any stall request so the discarded ID instruction never waits.
module hazard_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  ctrl_bundle_t id_ctrl_i,
    input  ctrl_bundle_t idex_i,
    input  ctrl_bundle_t exmem_i,
    input  ctrl_bundle_t memwb_i,
    input  logic         branch_eq_i,
    input  logic         branch_lt_i,
    input  logic         branch_ltu_i,
    output logic [1:0]   fwd_a_sel_o,
    output logic [1:0]   fwd_b_sel_o,
    output logic         raw_stall_o,
    output logic         flush_o,
    output logic [2:0]   next_pc_sel_o
);

    logic w_taken;
    logic w_raw;
    logic w_unused;

    assign w_unused = ^{id_ctrl_i, idex_i, exmem_i, memwb_i};

    // x0 is excluded here, so it can neither forward nor stall.
    function automatic logic wr_hit(input ctrl_bundle_t b, input logic [RA_W-1:0] rs);
        return b.rf_wen && (b.rd != '0) && (b.rd == rs);
    endfunction

    function automatic logic id_hit(input ctrl_bundle_t id, input ctrl_bundle_t b);
        return (id.use_rs1 && wr_hit(b, id.rs1)) || (id.use_rs2 && wr_hit(b, id.rs2));
    endfunction

    always_comb begin
        w_taken = idex_i.illegal || idex_i.is_jump ||
                  (idex_i.is_branch && branch_cond(idex_i.funct3, branch_eq_i,
                                                   branch_lt_i, branch_ltu_i));
        next_pc_sel_o = PC_PLUS4;
        if (idex_i.illegal)      next_pc_sel_o = PC_TRAP;
        else if (idex_i.is_jalr) next_pc_sel_o = PC_JALR;
        else if (idex_i.is_jump) next_pc_sel_o = PC_JAL;
        else if (w_taken)        next_pc_sel_o = PC_BRANCH;

        fwd_a_sel_o = FWD_RF;
        fwd_b_sel_o = FWD_RF;
        if (FWD_EN != 0) begin
            if (idex_i.use_rs1 && wr_hit(exmem_i, idex_i.rs1))      fwd_a_sel_o = FWD_EXMEM;
            else if (idex_i.use_rs1 && wr_hit(memwb_i, idex_i.rs1)) fwd_a_sel_o = FWD_MEMWB;
            if (idex_i.use_rs2 && wr_hit(exmem_i, idex_i.rs2))      fwd_b_sel_o = FWD_EXMEM;
            else if (idex_i.use_rs2 && wr_hit(memwb_i, idex_i.rs2)) fwd_b_sel_o = FWD_MEMWB;
            w_raw = idex_i.is_load && id_hit(id_ctrl_i, idex_i);
        end else begin
            w_raw = id_hit(id_ctrl_i, idex_i) || id_hit(id_ctrl_i, exmem_i) ||
                    id_hit(id_ctrl_i, memwb_i);
        end

        raw_stall_o = w_raw && !w_taken;
        flush_o     = w_taken;
    end

endmodule

// File: rtl/pipe_controller.sv
// RV32I pipeline control: ID decode (comb), bundles registered ID/EX -> EX/MEM -> MEM/WB, 1 cycle per stage.
// stall_ext_i freezes every stage register and the retire counter; hazards stall IF/ID and bubble ID/EX.
module pipe_controller
    import pipe_ctrl_pkg::*;
#(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_ext_i,
    input  logic              id_valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic              branch_eq_i,
    input  logic              branch_lt_i,
    input  logic              branch_ltu_i,
    output logic [2:0]        imm_type_o,
    output logic [3:0]        alu_op_o,
    output logic [1:0]        alu_src1_sel_o,
    output logic [1:0]        alu_src2_sel_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              mem_wen_o,
    output logic [2:0]        mem_size_o,
    output logic              mem_signed_o,
    output logic              rf_wen_o,
    output logic [1:0]        rf_wdata_sel_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [2:0]        next_pc_sel_o,
    output logic              pc_wen_o,
    output logic              ifid_wen_o,
    output logic              ifid_flush_o,
    output logic              illegal_instr_o,
    output logic [CNT_W-1:0]  instret_o
);

    ctrl_bundle_t     r_idex, r_exmem, r_memwb, w_dec;
    logic [CNT_W-1:0] r_instret;
    logic             w_legal, w_raw_stall, w_flush;
    logic [2:0]       w_imm_type;

    always_comb begin
        w_dec        = BUBBLE;
        w_imm_type   = IMM_I;
        w_legal      = 1'b1;
        w_dec.valid  = 1'b1;
        w_dec.funct3 = funct3_i;
        w_dec.rs1    = rs1_i;
        w_dec.rs2    = rs2_i;
        w_dec.rd     = rd_i;
        case (opcode_i)
            OPC_OP: begin
                {w_dec.use_rs1, w_dec.use_rs2, w_dec.rf_wen} = 3'b111;
                w_dec.alu_op = alu_from_f3(funct3_i, funct7_i[5]);
                w_legal = (funct7_i == 7'b0) || (funct7_i == 7'b0100000 &&
                          (funct3_i == 3'b000 || funct3_i == 3'b101));
            end
            OPC_OPIMM: begin
                {w_dec.use_rs1, w_dec.rf_wen} = 2'b11;
                w_dec.src2_sel = SRC2_IMM;
                w_dec.alu_op   = alu_from_f3(funct3_i, funct3_i == 3'b101 && funct7_i[5]);
                if (funct3_i == 3'b001)      w_legal = (funct7_i == 7'b0);
                else if (funct3_i == 3'b101) w_legal = (funct7_i == 7'b0) || (funct7_i == 7'b0100000);
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec.rf_wen   = 1'b1;
                w_dec.src1_sel = (opcode_i == OPC_LUI) ? SRC1_ZERO : SRC1_PC;
                w_dec.src2_sel = SRC2_IMM;
                w_imm_type     = IMM_U;
            end
            OPC_JAL, OPC_JALR: begin
                {w_dec.is_jump, w_dec.rf_wen} = 2'b11;
                w_dec.is_jalr   = (opcode_i == OPC_JALR);
                w_dec.use_rs1   = (opcode_i == OPC_JALR);
                w_dec.src1_sel  = (opcode_i == OPC_JALR) ? SRC1_RS1 : SRC1_PC;
                w_dec.src2_sel  = SRC2_IMM;
                w_dec.wdata_sel = WB_PC4;
                w_imm_type      = (opcode_i == OPC_JALR) ? IMM_I : IMM_J;
                if (opcode_i == OPC_JALR) w_legal = (funct3_i == 3'b000);
            end
            OPC_BRANCH: begin
                {w_dec.is_branch, w_dec.use_rs1, w_dec.use_rs2} = 3'b111;
                w_dec.src1_sel = SRC1_PC;
                w_dec.src2_sel = SRC2_IMM;
                w_imm_type     = IMM_B;
                w_legal        = (funct3_i[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                {w_dec.is_load, w_dec.use_rs1, w_dec.rf_wen} = 3'b111;
                w_dec.src2_sel   = SRC2_IMM;
                w_dec.wdata_sel  = WB_MEM;
                w_dec.mem_signed = !funct3_i[2];
                w_legal = (funct3_i != 3'b011) && (funct3_i[2:1] != 2'b11);
            end
            OPC_STORE: begin
                {w_dec.mem_wen, w_dec.use_rs1, w_dec.use_rs2} = 3'b111;
                w_dec.src2_sel = SRC2_IMM;
                w_imm_type     = IMM_S;
                w_legal        = !funct3_i[2] && (funct3_i != 3'b011);
            end
            OPC_FENCE: w_legal = 1'b1;
            default:   w_legal = 1'b0;
        endcase
        if (!w_dec.rf_wen) w_dec.rd = '0;
        // Trapping instructions travel with no enables and no register use, so they cannot stall.
        if (!w_legal) begin
            w_dec         = BUBBLE;
            w_dec.illegal = 1'b1;
        end
        if (!id_valid_i) w_dec = BUBBLE;
    end

    hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
        .id_ctrl_i     (w_dec),
        .idex_i        (r_idex),
        .exmem_i       (r_exmem),
        .memwb_i       (r_memwb),
        .branch_eq_i   (branch_eq_i),
        .branch_lt_i   (branch_lt_i),
        .branch_ltu_i  (branch_ltu_i),
        .fwd_a_sel_o   (fwd_a_sel_o),
        .fwd_b_sel_o   (fwd_b_sel_o),
        .raw_stall_o   (w_raw_stall),
        .flush_o       (w_flush),
        .next_pc_sel_o (next_pc_sel_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idex    <= BUBBLE;
            r_exmem   <= BUBBLE;
            r_memwb   <= BUBBLE;
            r_instret <= '0;
        end else if (!stall_ext_i) begin
            r_idex          <= (w_flush || w_raw_stall) ? BUBBLE : w_dec;
            r_exmem         <= r_idex;
            r_exmem.illegal <= 1'b0;
            r_memwb         <= r_exmem;
            if (r_memwb.valid) r_instret <= r_instret + 1'b1;
        end
    end

    assign imm_type_o      = w_imm_type;
    assign alu_op_o        = r_idex.alu_op;
    assign alu_src1_sel_o  = r_idex.src1_sel;
    assign alu_src2_sel_o  = r_idex.src2_sel;
    assign mem_wen_o       = r_exmem.mem_wen;
    assign mem_size_o      = r_exmem.funct3;
    assign mem_signed_o    = r_exmem.mem_signed;
    assign rf_wen_o        = r_memwb.rf_wen;
    assign rf_wdata_sel_o  = r_memwb.wdata_sel;
    assign wb_rd_o         = r_memwb.rd;
    assign pc_wen_o        = !stall_ext_i && !w_raw_stall;
    assign ifid_wen_o      = !stall_ext_i && !w_raw_stall;
    assign ifid_flush_o    = w_flush;
    assign illegal_instr_o = r_idex.illegal && !stall_ext_i;
    assign instret_o       = r_instret;

endmodule

// File: tb/tb_pipe_controller.sv
// Directed bench: forwarding instance with a 4-bit retire counter, plus a no-forwarding instance on the same inputs.
module tb_pipe_controller;

    logic       clk = 1'b0;
    logic       rst, stall_ext, id_valid, beq_i, blt_i, bltu_i;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    logic [2:0] imm_type, mem_size, npc;
    logic [3:0] alu_op, instret;
    logic [1:0] src1, src2, fwd_a, fwd_b, wdsel;
    logic       mem_wen, mem_signed, rf_wen, pc_wen, ifid_wen, flush, ill;
    logic [4:0] wb_rd;

    logic [2:0]  n_imm_type, n_mem_size, n_npc;
    logic [3:0]  n_alu_op;
    logic [1:0]  n_src1, n_src2, n_fwd_a, n_fwd_b, n_wdsel;
    logic        n_mem_wen, n_mem_signed, n_rf_wen, n_pc_wen, n_ifid_wen, n_flush, n_ill;
    logic [4:0]  n_wb_rd;
    logic [31:0] n_instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_controller #(.FWD_EN(1), .CNT_W(4), .REG_AW(5)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_ext_i(stall_ext), .id_valid_i(id_valid),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .branch_eq_i(beq_i), .branch_lt_i(blt_i), .branch_ltu_i(bltu_i),
        .imm_type_o(imm_type), .alu_op_o(alu_op), .alu_src1_sel_o(src1), .alu_src2_sel_o(src2),
        .fwd_a_sel_o(fwd_a), .fwd_b_sel_o(fwd_b), .mem_wen_o(mem_wen), .mem_size_o(mem_size),
        .mem_signed_o(mem_signed), .rf_wen_o(rf_wen), .rf_wdata_sel_o(wdsel), .wb_rd_o(wb_rd),
        .next_pc_sel_o(npc), .pc_wen_o(pc_wen), .ifid_wen_o(ifid_wen), .ifid_flush_o(flush),
        .illegal_instr_o(ill), .instret_o(instret)
    );

    pipe_controller #(.FWD_EN(0), .CNT_W(32), .REG_AW(5)) u_nf (
        .clk_i(clk), .rst_i(rst), .stall_ext_i(stall_ext), .id_valid_i(id_valid),
        .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
        .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .branch_eq_i(beq_i), .branch_lt_i(blt_i), .branch_ltu_i(bltu_i),
        .imm_type_o(n_imm_type), .alu_op_o(n_alu_op), .alu_src1_sel_o(n_src1), .alu_src2_sel_o(n_src2),
        .fwd_a_sel_o(n_fwd_a), .fwd_b_sel_o(n_fwd_b), .mem_wen_o(n_mem_wen), .mem_size_o(n_mem_size),
        .mem_signed_o(n_mem_signed), .rf_wen_o(n_rf_wen), .rf_wdata_sel_o(n_wdsel), .wb_rd_o(n_wb_rd),
        .next_pc_sel_o(n_npc), .pc_wen_o(n_pc_wen), .ifid_wen_o(n_ifid_wen), .ifid_flush_o(n_flush),
        .illegal_instr_o(n_ill), .instret_o(n_instret)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d);
        id_valid = v; opcode = op; funct3 = f3; funct7 = f7; rs1 = a; rs2 = b; rd = d;
    endtask

    task automatic nop();                                   drive(1'b0, 7'b0, 3'b0, 7'b0, 5'd0, 5'd0, 5'd0); endtask
    task automatic add(input logic [4:0] d, a, b);          drive(1'b1, 7'b0110011, 3'b000, 7'b0, a, b, d); endtask
    task automatic sub(input logic [4:0] d, a, b);          drive(1'b1, 7'b0110011, 3'b000, 7'b0100000, a, b, d); endtask
    task automatic br(input logic [2:0] f3);                drive(1'b1, 7'b1100011, f3, 7'b0, 5'd1, 5'd2, 5'd0); endtask
    task automatic idle(input int n);                       nop(); repeat (n) tick(); endtask

    initial begin
        rst = 1'b1; stall_ext = 1'b0; beq_i = 1'b0; blt_i = 1'b0; bltu_i = 1'b0;
        nop();
        tick(); tick();
        rst = 1'b0; #1;
        chk("rst_npc", npc, 3'b000);   chk("rst_pcw", pc_wen, 1);  chk("rst_ifw", ifid_wen, 1);
        chk("rst_flush", flush, 0);    chk("rst_ill", ill, 0);     chk("rst_fa", fwd_a, 0);
        chk("rst_fb", fwd_b, 0);       chk("rst_cnt", instret, 0); chk("rst_rfw", rf_wen, 0);

        // add x3,x1,x2
        add(5'd3, 5'd1, 5'd2); #1; chk("add_imm", imm_type, 3'b000); tick();
        nop(); #1; chk("add_alu", alu_op, 4'b0000); chk("add_src2", src2, 0); tick();
        #1; chk("add_memw", mem_wen, 0); tick();
        #1; chk("add_rfw", rf_wen, 1); chk("add_rd", wb_rd, 3); chk("add_wds", wdsel, 0); tick();
        #1; chk("add_cnt", instret, 1);

        // sw x2,0(x1)
        drive(1'b1, 7'b0100011, 3'b010, 7'b0, 5'd1, 5'd2, 5'd9); #1; chk("sw_imm", imm_type, 3'b001); tick();
        nop(); #1; chk("sw_src2", src2, 1); tick();
        #1; chk("sw_memw", mem_wen, 1); chk("sw_size", mem_size, 3'b010); tick();
        #1; chk("sw_rfw", rf_wen, 0); tick();
        #1; chk("sw_cnt", instret, 2);

        // back-to-back RAW -> EX/MEM forward
        add(5'd5, 5'd1, 5'd2); tick();
        sub(5'd6, 5'd5, 5'd1); #1; chk("t2_pcw", pc_wen, 1); tick();
        nop(); #1; chk("t2_alu", alu_op, 4'b0001); chk("t2_fa", fwd_a, 2'b01); chk("t2_fb", fwd_b, 2'b00);
        idle(4); chk("t2_cnt", instret, 4);

        // one bubble between -> MEM/WB forward
        add(5'd5, 5'd1, 5'd2); tick(); nop(); tick();
        sub(5'd6, 5'd5, 5'd1); tick();
        nop(); #1; chk("t2b_fa", fwd_a, 2'b10);
        idle(4); chk("t2b_cnt", instret, 6);

        // lw x7 then add x8,x7,x0
        drive(1'b1, 7'b0000011, 3'b010, 7'b0, 5'd1, 5'd0, 5'd7); tick();
        add(5'd8, 5'd7, 5'd0); #1; chk("lu_pcw", pc_wen, 0); chk("lu_ifw", ifid_wen, 0); tick();
        #1; chk("lu_pcw2", pc_wen, 1); chk("lu_ifw2", ifid_wen, 1);
        chk("lu_size", mem_size, 3'b010); chk("lu_sgn", mem_signed, 1); tick();
        nop(); #1; chk("lu_fa", fwd_a, 2'b10); chk("lu_fb", fwd_b, 2'b00);
        chk("lu_wds", wdsel, 2'b01); chk("lu_rd", wb_rd, 7);
        idle(4); chk("lu_cnt", instret, 8);

        // beq taken
        br(3'b000); tick();
        add(5'd9, 5'd1, 5'd2); beq_i = 1'b1; #1;
        chk("bt_npc", npc, 3'b001); chk("bt_flush", flush, 1); chk("bt_pcw", pc_wen, 1); tick();
        nop(); beq_i = 1'b0; #1; chk("bt_flush2", flush, 0); chk("bt_rfw2", rf_wen, 0); tick();
        #1; chk("bt_rfw3", rf_wen, 0); tick();
        #1; chk("bt_rfw4", rf_wen, 0);
        idle(3); chk("bt_cnt", instret, 9);

        // beq not taken
        br(3'b000); tick();
        add(5'd9, 5'd1, 5'd2); #1; chk("bn_npc", npc, 3'b000); chk("bn_flush", flush, 0); tick();
        nop(); tick(); tick();
        #1; chk("bn_rfw", rf_wen, 1); chk("bn_rd", wb_rd, 9);
        idle(3); chk("bn_cnt", instret, 11);

        // bge with lt=1 not taken; bltu with ltu=1 taken; jal
        br(3'b101); tick();
        nop(); blt_i = 1'b1; #1; chk("bge_npc", npc, 3'b000); chk("bge_flush", flush, 0); tick();
        blt_i = 1'b0; idle(4);
        br(3'b110); tick();
        nop(); bltu_i = 1'b1; beq_i = 1'b1; #1; chk("bltu_npc", npc, 3'b001); tick();
        bltu_i = 1'b0; beq_i = 1'b0; idle(4);
        drive(1'b1, 7'b1101111, 3'b000, 7'b0, 5'd0, 5'd0, 5'd1); #1; chk("jal_imm", imm_type, 3'b100); tick();
        nop(); #1; chk("jal_npc", npc, 3'b010); chk("jal_flush", flush, 1); tick();
        idle(4); chk("jal_cnt", instret, 14);

        // illegal opcode under a 3-cycle external stall, with an add retiring meanwhile
        add(5'd10, 5'd1, 5'd2); tick(); nop(); tick();
        drive(1'b1, 7'b1111111, 3'b000, 7'b0, 5'd0, 5'd0, 5'd0); tick();
        nop(); stall_ext = 1'b1; #1;
        chk("il_p0", ill, 0); chk("il_npc", npc, 3'b100); chk("il_pcw", pc_wen, 0);
        chk("il_ifw", ifid_wen, 0); chk("il_flush", flush, 1); chk("il_cnt0", instret, 14); tick();
        #1; chk("il_p1", ill, 0); chk("il_cnt1", instret, 14); tick();
        #1; chk("il_p2", ill, 0); chk("il_cnt2", instret, 14); tick();
        stall_ext = 1'b0; #1; chk("il_pulse", ill, 1); chk("il_npc2", npc, 3'b100); chk("il_cnt3", instret, 14); tick();
        #1; chk("il_after", ill, 0); chk("il_npc3", npc, 3'b000); chk("il_cnt4", instret, 15);
        idle(3); chk("il_cnt5", instret, 15);

        // 4-bit counter wrap
        add(5'd11, 5'd1, 5'd2); tick(); add(5'd12, 5'd1, 5'd2); tick(); nop(); tick();
        #1; chk("wr_15", instret, 15); tick();
        #1; chk("wr_0", instret, 0); tick();
        #1; chk("wr_1", instret, 1);
        idle(3);

        // reset mid-stream
        add(5'd13, 5'd1, 5'd2); tick(); add(5'd14, 5'd1, 5'd2); tick();
        add(5'd15, 5'd1, 5'd2); tick(); add(5'd16, 5'd1, 5'd2); #1;
        chk("rm_rfw0", rf_wen, 1); chk("rm_rd0", wb_rd, 13);
        rst = 1'b1; tick();
        rst = 1'b0; nop(); #1;
        chk("rm_rfw1", rf_wen, 0); chk("rm_memw1", mem_wen, 0); chk("rm_cnt", instret, 0); tick();
        #1; chk("rm_rfw2", rf_wen, 0); tick();
        #1; chk("rm_rfw3", rf_wen, 0);
        idle(2);

        // no-forwarding instance: x0 never stalls, real RAW stalls until the producer clears
        add(5'd0, 5'd1, 5'd2); tick();
        add(5'd4, 5'd0, 5'd0); #1; chk("nf_x0", n_pc_wen, 1); tick();
        idle(4);
        add(5'd5, 5'd1, 5'd2); tick();
        sub(5'd6, 5'd5, 5'd1); #1;
        chk("nf_st1", n_pc_wen, 0); chk("nf_ifw1", n_ifid_wen, 0); chk("fw_nostall", pc_wen, 1); tick();
        #1; chk("nf_st2", n_pc_wen, 0);
        for (int i = 0; i < 4 && n_pc_wen !== 1'b1; i++) tick();
        chk("nf_resume", n_pc_wen, 1);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
